// File: rtl/lfsr_block_packer_if.sv
// rtl/lfsr_block_packer_if.sv - block handshake bundle between the packer and its consumer
interface lfsr_block_packer_if #(
  parameter int WORD_BITS       = 32,
  parameter int WORDS_PER_BLOCK = 4
);
  logic                                 o_Block_Valid;
  logic                                 i_Block_Ready;
  logic [WORD_BITS*WORDS_PER_BLOCK-1:0] o_Block_Data;

  modport master (
    output o_Block_Valid,
    output o_Block_Data,
    input  i_Block_Ready
  );

  modport slave (
    input  o_Block_Valid,
    input  o_Block_Data,
    output i_Block_Ready
  );
endinterface

// File: rtl/lfsr_block_packer.sv
// rtl/lfsr_block_packer.sv - seeds and steps an external LFSR, packing its words into handshaked blocks
module lfsr_block_packer #(
  parameter int WORD_BITS       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int CNT_BITS        = 16
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_Start,
  input  logic [WORD_BITS-1:0]  i_Seed,
  input  logic [CNT_BITS-1:0]   i_Num_Blocks,
  output logic                  o_LFSR_Enable,
  output logic                  o_LFSR_Seed_DV,
  output logic [WORD_BITS-1:0]  o_LFSR_Seed_Data,
  input  logic [WORD_BITS-1:0]  i_LFSR_Data,
  lfsr_block_packer_if.master   blk,
  output logic [CNT_BITS-1:0]   o_Block_Count,
  output logic                  o_Busy,
  output logic                  o_Done
);

  localparam int BLK_BITS = WORD_BITS * WORDS_PER_BLOCK;
  localparam int IDX_BITS = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(WORDS_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_FILL,
    S_HOLD,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WORD_BITS-1:0] seed_q, seed_d;
  logic [CNT_BITS-1:0]  num_q, num_d;
  logic [CNT_BITS-1:0]  count_q, count_d;
  logic [BLK_BITS-1:0]  data_q, data_d;
  logic                 valid_q, valid_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic                 lfsr_en;
  logic                 seed_dv;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      num_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      num_q   <= num_d;
      count_q <= count_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    num_d   = num_q;
    count_d = count_q;
    data_d  = data_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    lfsr_en = 1'b0;
    seed_dv = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_Start) begin
          seed_d  = i_Seed;
          num_d   = i_Num_Blocks;
          count_d = '0;
          state_d = S_SEED;
        end
      end

      S_SEED: begin
        lfsr_en = 1'b1;
        seed_dv = 1'b1;
        idx_d   = '0;
        state_d = S_FILL;
      end

      S_FILL: begin
        // Shift left so the first word of the block ends up in the MSBs.
        lfsr_en = 1'b1;
        data_d  = (data_q << WORD_BITS) | BLK_BITS'(i_LFSR_Data);
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (valid_q && blk.i_Block_Ready) begin
          count_d = count_q + CNT_BITS'(1);
          valid_d = 1'b0;
          if ((num_q != '0) && (count_d == num_q)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_LFSR_Enable    = lfsr_en;
  assign o_LFSR_Seed_DV   = seed_dv;
  assign o_LFSR_Seed_Data = seed_q;
  assign blk.o_Block_Valid = valid_q;
  assign blk.o_Block_Data  = data_q;
  assign o_Block_Count    = count_q;
  assign o_Busy           = (state_q == S_SEED) || (state_q == S_FILL) || (state_q == S_HOLD);
  assign o_Done           = (state_q == S_DONE);

endmodule
